// File: rtl/adder_pkg.sv
// Shared constants and types for the pipelined add/subtract unit.
package adder_pkg;

   localparam logic MODE_ADD       = 1'b0;
   localparam logic MODE_SUB       = 1'b1;
   localparam int   N_DEFAULT      = 32;
   localparam int   STAGES_DEFAULT = 4;

   typedef struct packed {
      logic c;
      logic v;
      logic z;
   } flags_t;

endpackage

// File: rtl/adder_stage.sv
// One chunk of the pipelined adder: CHUNK-bit add with carry, plus the stage valid bit.
module adder_stage #(
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic             vin,
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic             v,
   output logic [CHUNK-1:0] s,
   output logic [CHUNK-1:0] s_nxt,
   output logic             c
);

   logic c_nxt;

   assign {c_nxt, s_nxt} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

   // data only moves with a real operation so results hold through bubbles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v <= 1'b0;
         s <= '0;
         c <= 1'b0;
      end else if (ld) begin
         v <= vin;
         if (vin) begin
            s <= s_nxt;
            c <= c_nxt;
         end
      end
   end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined n-bit add/subtract unit: carry ripples through one registered stage per
// chunk, with ready/valid handshakes and carry/overflow/zero flags.
module pipe_adder
   import adder_pkg::*;
#(
   parameter int n      = N_DEFAULT,
   parameter int STAGES = STAGES_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [n-1:0] A,
   input  logic [n-1:0] B,
   input  logic         SUB,
   input  logic         CIN,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [n-1:0] OUT,
   output logic         C,
   output logic         V,
   output logic         Z,
   output logic         out_valid,
   input  logic         out_ready
);

   localparam int CHUNK = n / STAGES;

   logic [n-1:0]      bx;
   logic              c0;
   logic [STAGES-1:0] v, vin, ld, cy;
   logic [CHUNK-1:0]  sq    [STAGES];
   logic [CHUNK-1:0]  sn    [STAGES];
   logic [n-1:0]      opa   [STAGES];
   logic [n-1:0]      opb   [STAGES];
   logic [n-1:0]      lo    [STAGES];
   logic [n-1:0]      lo_in [STAGES];
   logic [n-1:0]      zw;
   logic              z_q;
   flags_t            fl;

   assign bx = (SUB == MODE_ADD) ? B : ~B;
   assign c0 = CIN ^ (SUB == MODE_SUB);

   // a stage may load when empty or when its successor is loading this cycle
   always_comb begin
      ld = '0;
      ld[STAGES-1] = !v[STAGES-1] || out_ready;
      for (int unsigned i = 1; i < STAGES; i++)
         ld[STAGES-1-i] = !v[STAGES-1-i] || ld[STAGES-i];
   end

   assign in_ready = !rst && ld[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [n-1:0] a_src, b_src, lo_src;
      logic [n-1:0] a_q, b_q, lo_q;
      logic         cin;

      if (k == 0) begin : g_first
         assign a_src  = A;
         assign b_src  = bx;
         assign cin    = c0;
         assign vin[0] = in_valid && in_ready;
         assign lo_src = '0;
      end else begin : g_next
         assign a_src  = opa[k-1];
         assign b_src  = opb[k-1];
         assign cin    = cy[k-1];
         assign vin[k] = v[k-1];
         always_comb begin
            lo_src = lo[k-1];
            lo_src[(k-1)*CHUNK +: CHUNK] = sq[k-1];
         end
      end

      adder_stage #(.CHUNK(CHUNK)) u_stage (
         .clk   (clk),
         .rst   (rst),
         .ld    (ld[k]),
         .vin   (vin[k]),
         .a     (a_src[k*CHUNK +: CHUNK]),
         .b     (b_src[k*CHUNK +: CHUNK]),
         .cin   (cin),
         .v     (v[k]),
         .s     (sq[k]),
         .s_nxt (sn[k]),
         .c     (cy[k])
      );

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            lo_q <= '0;
         end else if (ld[k] && vin[k]) begin
            a_q  <= a_src;
            b_q  <= b_src;
            lo_q <= lo_src;
         end
      end

      assign opa[k]   = a_q;
      assign opb[k]   = b_q;
      assign lo[k]    = lo_q;
      assign lo_in[k] = lo_src;
   end

   always_comb begin
      OUT = lo[STAGES-1];
      OUT[(STAGES-1)*CHUNK +: CHUNK] = sq[STAGES-1];
   end

   // zero flag is registered alongside the last stage so it reads 0 out of reset
   always_comb begin
      zw = lo_in[STAGES-1];
      zw[(STAGES-1)*CHUNK +: CHUNK] = sn[STAGES-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         z_q <= 1'b0;
      else if (ld[STAGES-1] && vin[STAGES-1])
         z_q <= ~|zw;
   end

   assign fl.c = cy[STAGES-1];
   assign fl.v = (opa[STAGES-1][n-1] == opb[STAGES-1][n-1]) && (OUT[n-1] != opa[STAGES-1][n-1]);
   assign fl.z = z_q;

   assign {C, V, Z}  = fl;
   assign out_valid  = v[STAGES-1];

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: the driver queues hand-computed results, a
// negedge monitor compares every presented output against the queue head.
module tb_pipe_adder;

   localparam int N = 32;
   localparam int S = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] A, B, OUT;
   logic         SUB, CIN, in_valid, in_ready, C, V, Z, out_valid, out_ready;

   typedef struct {
      logic [N-1:0] out;
      logic         c, v, z;
      int unsigned  cyc;
      bit           lat;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   int          total = 0;
   int          bad = 0;
   int          accepts = 0;
   int          results = 0;
   int unsigned cyc = 0;

   pipe_adder #(.n(N), .STAGES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .A         (A),
      .B         (B),
      .SUB       (SUB),
      .CIN       (CIN),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .OUT       (OUT),
      .C         (C),
      .V         (V),
      .Z         (Z),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub,
                       input logic cin, input logic [N-1:0] eo, input logic ec,
                       input logic ev, input logic ez, input bit lat);
      bit          acc = 0;
      int unsigned ic = 0;
      A = a; B = b; SUB = sub; CIN = cin; in_valid = 1'b1;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         ic  = cyc;
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         total++; bad++;
         $display("FAIL send_timeout: op %h/%h never accepted", a, b);
      end else begin
         q.push_back('{eo, ec, ev, ez, ic, lat});
         accepts++;
      end
      in_valid = 1'b0;
      A = $urandom; B = $urandom; SUB = 1'($urandom); CIN = 1'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
      #1;
      if (q.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_timeout: %0d results outstanding, 0 required", q.size());
      end
   endtask

   // stalled outputs are compared without popping, so they must hold their value
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_output: got %h, no result expected", OUT);
         end else begin
            e = q[0];
            check("out", OUT, e.out);
            check("c", {31'b0, C}, {31'b0, e.c});
            check("v", {31'b0, V}, {31'b0, e.v});
            check("z", {31'b0, Z}, {31'b0, e.z});
            if (out_ready) begin
               if (e.lat) check("latency", cyc - e.cyc, S);
               void'(q.pop_front());
               results++;
            end
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; SUB = 1'b0; CIN = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd0);
      check("rst_out", OUT, 32'd0);
      check("rst_flags", {29'b0, C, V, Z}, 32'd0);
      rst = 1'b0;
      #1;
      check("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

      // back-to-back adds, then subtract and flag boundaries
      send(32'd4542, 32'd5482, 1'b0, 1'b0, 32'd10024, 1'b0, 1'b0, 1'b0, 1);
      send(32'd4253, 32'd415, 1'b0, 1'b0, 32'd4668, 1'b0, 1'b0, 1'b0, 1);
      send(32'd759, 32'd7458, 1'b1, 1'b0, 32'hFFFFE5D5, 1'b0, 1'b0, 1'b0, 1);
      send(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1);
      send(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1);
      send(32'd42566, 32'd42566, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1);
      send(32'h00FFFFFF, 32'd0, 1'b0, 1'b1, 32'h01000000, 1'b0, 1'b0, 1'b0, 1);
      drain();

      // back-pressure: five offered, four fit while out_ready is low
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      accepts = 0;
      results = 0;
      fork
         begin
            send(32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0, 0);
            send(32'd10, 32'd20, 1'b0, 1'b0, 32'd30, 1'b0, 1'b0, 1'b0, 0);
            send(32'd100, 32'd200, 1'b0, 1'b0, 32'd300, 1'b0, 1'b0, 1'b0, 0);
            send(32'd1000, 32'd2000, 1'b0, 1'b0, 32'd3000, 1'b0, 1'b0, 1'b0, 0);
            send(32'd5, 32'd3, 1'b1, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0, 0);
         end
         begin
            repeat (8) @(posedge clk);
            #2;
            check("bp_accepts_stalled", accepts, 32'd4);
            check("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
            out_ready = 1'b1;
            @(negedge clk);
            check("bp_in_ready_release", {31'b0, in_ready}, 32'd1);
            @(posedge clk);
            #2;
            check("bp_accepts_release", accepts, 32'd5);
         end
      join
      drain();
      check("bp_result_count", results, 32'd5);

      // reset with three operations in flight
      out_ready = 1'b0;
      send(32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 0);
      send(32'd7, 32'd8, 1'b0, 1'b0, 32'd15, 1'b0, 1'b0, 1'b0, 0);
      send(32'd9, 32'd9, 1'b0, 1'b0, 32'd18, 1'b0, 1'b0, 1'b0, 0);
      @(posedge clk);
      #1;
      check("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
      rst = 1'b1;
      q.delete();
      #1;
      check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
      check("mid_rst_out", OUT, 32'd0);
      check("mid_rst_flags", {29'b0, C, V, Z}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
      results = 0;
      repeat (6) @(posedge clk);
      #1;
      send(32'd123, 32'd456, 1'b0, 1'b0, 32'd579, 1'b0, 1'b0, 1'b0, 1);
      drain();
      repeat (3) @(posedge clk);
      #1;
      check("post_rst_result_count", results, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
